// File: rtl/apb_master_cmd_engine.sv
// APB3/APB4 master command engine: buffers valid/ready requests in a small
// FIFO, runs each one as an APB SETUP/ACCESS transfer with wait-state timeout,
// and returns one registered response per request.
module apb_master_cmd_engine #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int CMD_W  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_SLV = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state_q, state_d;

  logic [CMD_W-1:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  fifo_empty, fifo_full, push, pop;

  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [STRB_W-1:0]     head_strb;

  logic                  cmd_write_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic [STRB_W-1:0]     cmd_strb_q;

  logic [7:0]            to_cnt_q, to_cnt_d;
  logic                  psel_q, penable_q;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_err_q, rsp_err_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;

  assign {head_write, head_addr, head_wdata, head_strb} = fifo_mem_q[rd_ptr_q];

  // FIFO storage: data only, contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {req_write, req_addr, req_wdata, req_strb};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state, pop, timeout and response decisions
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    to_cnt_d    = to_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          to_cnt_d = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr ? ERR_SLV : ERR_OK;
          rsp_rdata_d = (!cmd_write_q && !pslverr) ? prdata : '0;
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d    = to_cnt_q + 8'd1;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TO;
          rsp_rdata_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = ERR_OK;
          if (!fifo_empty) begin
            pop      = 1'b1;
            to_cnt_d = '0;
            state_d  = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, APB phase outputs and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q   <= (state_d == ACCESS);
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Command register drives the APB address/data; write-only fields zeroed for reads
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_strb_q  <= '0;
    end else if (pop) begin
      cmd_write_q <= head_write;
      cmd_addr_q  <= head_addr;
      cmd_wdata_q <= head_write ? head_wdata : '0;
      cmd_strb_q  <= head_write ? head_strb : '0;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = cmd_write_q;
  assign paddr     = cmd_addr_q;
  assign pwdata    = cmd_wdata_q;
  assign pstrb     = cmd_strb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_cmd_engine.sv
// Scoreboard bench for apb_master_cmd_engine: requests push expected responses
// into a queue, a monitor pops and compares on each response handshake.
module tb_apb_master_cmd_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

  // slave model configuration
  int          slave_wait = 0;
  bit          slave_never = 0, slave_err_ready = 0, slave_err_early = 0, slave_addr_data = 0;
  logic [31:0] slave_rdata = 32'h0;
  logic [7:0]  acc_cnt;

  apb_master_cmd_engine #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  assign pready  = psel && penable && !slave_never && (int'(acc_cnt) >= slave_wait);
  assign pslverr = psel && penable && ((pready && slave_err_ready) || (!pready && slave_err_early));
  assign prdata  = slave_addr_data ? {16'hC0DE, paddr[15:0]} : slave_rdata;

  always @(posedge clk) begin
    if (rst || !penable) acc_cnt <= 8'd0;
    else if (!pready)    acc_cnt <= acc_cnt + 8'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata 0x%0h err %0d, expected no response", rsp_rdata, rsp_err);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e[33:2]});
        check("rsp_err", {62'h0, rsp_err}, {62'h0, e[1:0]});
      end
    end
  end

  task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input bit expect_rsp,
                      input logic [31:0] exp_rdata, input logic [1:0] exp_err);
    int guard = 0;
    if (expect_rsp) exp_q.push_back({exp_rdata, exp_err});
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
    @(negedge clk);
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_accept: req_ready stuck at 0, expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
  endtask

  task automatic watch_xfer(input string name, input logic [31:0] exp_addr, input int exp_pen);
    int pen = 0;
    int guard = 0;
    bit addr_ok = 1'b1;
    @(negedge clk);
    while (!psel && guard < 100) begin @(negedge clk); guard++; end
    while (psel && guard < 400) begin
      if (paddr !== exp_addr) addr_ok = 1'b0;
      if (penable) pen++;
      @(negedge clk); guard++;
    end
    check({name, "_penable_cycles"}, 64'(pen), 64'(exp_pen));
    check({name, "_paddr_stable"}, {63'h0, addr_ok}, 64'd1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || rsp_valid || psel) && guard < 500) begin @(negedge clk); guard++; end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, bad, low_run, hi;
    bit prev;
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state
    check("rst_psel", {63'h0, psel}, 64'd0);
    check("rst_penable", {63'h0, penable}, 64'd0);
    check("rst_pwrite", {63'h0, pwrite}, 64'd0);
    check("rst_paddr", {32'h0, paddr}, 64'd0);
    check("rst_pwdata", {32'h0, pwdata}, 64'd0);
    check("rst_pstrb", {60'h0, pstrb}, 64'd0);
    check("rst_rsp_valid", {63'h0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'h0, rsp_rdata}, 64'd0);
    check("rst_rsp_err", {62'h0, rsp_err}, 64'd0);
    check("rst_req_ready", {63'h0, req_ready}, 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // zero-wait write latency
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 2'b00);
    @(negedge clk);
    check("lat_n1_psel", {63'h0, psel}, 64'd0);
    @(negedge clk);
    check("lat_n2_psel", {63'h0, psel}, 64'd1);
    check("lat_n2_penable", {63'h0, penable}, 64'd0);
    check("lat_n2_paddr", {32'h0, paddr}, 64'h10);
    check("lat_n2_pwdata", {32'h0, pwdata}, 64'hDEAD_BEEF);
    check("lat_n2_pstrb", {60'h0, pstrb}, 64'hF);
    check("lat_n2_pwrite", {63'h0, pwrite}, 64'd1);
    @(negedge clk);
    check("lat_n3_penable", {63'h0, penable}, 64'd1);
    check("lat_n3_pstrb", {60'h0, pstrb}, 64'hF);
    @(negedge clk);
    check("lat_n4_rsp_valid", {63'h0, rsp_valid}, 64'd1);
    check("lat_n4_psel", {63'h0, psel}, 64'd0);
    drain();

    // read with 3 wait states
    slave_wait = 3; slave_rdata = 32'h1234_5678;
    send(1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h1234_5678, 2'b00);
    watch_xfer("rd_wait", 32'h20, 4);
    drain();

    // pslverr during wait states is ignored
    slave_wait = 2; slave_err_early = 1'b1; slave_rdata = 32'h0BAD_F00D;
    send(1'b0, 32'h30, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D, 2'b00);
    drain();
    slave_err_early = 1'b0; slave_wait = 0;

    // slave error on write and on read: rdata forced to 0
    slave_err_ready = 1'b1; slave_rdata = 32'hFFFF_FFFF;
    send(1'b1, 32'h40, 32'h5555_AAAA, 4'h3, 1'b1, 32'h0, 2'b01);
    drain();
    send(1'b0, 32'h50, 32'h0, 4'h0, 1'b1, 32'h0, 2'b01);
    @(negedge clk); @(negedge clk);
    check("rd_pstrb_zero", {60'h0, pstrb}, 64'd0);
    check("rd_pwdata_zero", {32'h0, pwdata}, 64'd0);
    drain();
    slave_err_ready = 1'b0;

    // wait-state timeout
    slave_never = 1'b1;
    send(1'b0, 32'h60, 32'h0, 4'h0, 1'b1, 32'h0, 2'b10);
    watch_xfer("timeout", 32'h60, 16);
    drain();
    slave_never = 1'b0;

    // backpressure: 5 accepted, 6th must stall
    slave_addr_data = 1'b1;
    rsp_ready = 1'b0;
    send(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'hC0DE_0100, 2'b00);
    send(1'b0, 32'h104, 32'h0, 4'h0, 1'b1, 32'hC0DE_0104, 2'b00);
    send(1'b1, 32'h108, 32'h1111_2222, 4'hC, 1'b1, 32'h0, 2'b00);
    send(1'b0, 32'h10C, 32'h0, 4'h0, 1'b1, 32'hC0DE_010C, 2'b00);
    send(1'b0, 32'h110, 32'h0, 4'h0, 1'b1, 32'hC0DE_0110, 2'b00);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h114; req_wdata = 32'h9; req_strb = 4'hF;
    hi = 0;
    repeat (8) begin @(negedge clk); if (req_ready) hi++; end
    check("bp_req_ready_low", 64'(hi), 64'd0);
    check("bp_rsp_valid_held", {63'h0, rsp_valid}, 64'd1);
    check("bp_rsp_rdata_held", {32'h0, rsp_rdata}, 64'hC0DE_0100);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rsp_ready = 1'b1;
    rises = 0; bad = 0; low_run = 0; prev = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (psel) begin
        if (!prev) begin rises++; if (low_run != 1) bad++; end
        low_run = 0;
      end else begin
        low_run++;
      end
      prev = psel;
    end
    check("bp_transfers_after_release", 64'(rises), 64'd4);
    check("bp_idle_gap_errors", 64'(bad), 64'd0);
    drain();

    // reset mid-ACCESS with requests queued: no response may follow
    slave_wait = 5;
    send(1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00);
    send(1'b0, 32'h204, 32'h0, 4'h0, 1'b0, 32'h0, 2'b00);
    send(1'b1, 32'h208, 32'h7, 4'h1, 1'b0, 32'h0, 2'b00);
    hi = 0;
    while (!penable && hi < 50) begin @(negedge clk); hi++; end
    check("rst_mid_in_access", {63'h0, penable}, 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_psel", {63'h0, psel}, 64'd0);
    check("rstmid_penable", {63'h0, penable}, 64'd0);
    check("rstmid_paddr", {32'h0, paddr}, 64'd0);
    check("rstmid_pwrite", {63'h0, pwrite}, 64'd0);
    check("rstmid_rsp_valid", {63'h0, rsp_valid}, 64'd0);
    check("rstmid_req_ready", {63'h0, req_ready}, 64'd1);
    hi = 0;
    repeat (20) begin @(negedge clk); if (psel || rsp_valid) hi++; end
    check("rstmid_no_activity", 64'(hi), 64'd0);

    // recovery after reset
    slave_wait = 0; slave_addr_data = 1'b0;
    @(posedge clk); #1;
    send(1'b1, 32'h300, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0, 2'b00);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_cmd_engine.md
Name: apb_master_cmd_engine

Overview:
- Synthesizable APB master protocol engine sitting directly downstream of the apb_master HDL package.
- Consumes request commands through a valid/ready port and buffers them in a small FIFO.
- Drives APB3/APB4 SETUP/ACCESS phases, handles wait states, PSLVERR and a wait-state timeout.
- Returns one response per request through a valid/ready response port.
- Serves as the HDL-side DUT stimulus source for the apb_master agent's monitor and for the APB slave blocks.

Parameters:
- ADDR_WIDTH, 32, width of paddr and req_addr.
- DATA_WIDTH, 32, width of data buses; must be 8, 16 or 32.
- FIFO_DEPTH, 4, request FIFO entries; power of two, 2..16.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before abort; range 1..255.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; equals !full.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  target address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  byte strobes; ignored for reads.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  2  00=OKAY, 01=SLVERR, 10=TIMEOUT.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes; 0 on reads.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  slave ready.
- pslverr  in  1  slave error; sampled only with pready.

Behaviour:
- Reset (rst=1 at an edge): every output 0, except req_ready=1. FSM goes to IDLE, FIFO is emptied, timeout counter is 0. Takes effect even mid-transfer; psel/penable drop the cycle after the reset edge, and no response is issued for the aborted or buffered requests.
- FIFO:
  - Push on req_valid&&req_ready; pop when the FSM loads a command.
  - Pointers wrap modulo FIFO_DEPTH; occupancy count has width log2(FIFO_DEPTH)+1.
  - req_ready=!full, so no push occurs while full even if a pop happens in the same cycle.
  - Push and pop in the same cycle with 0<count<FIFO_DEPTH leaves count unchanged.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: if FIFO is non-empty, pop the head into the command register and go to SETUP.
  - SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb from the command register. Go to ACCESS next cycle unconditionally.
  - ACCESS: psel=1, penable=1; address/control held stable.
    - If pready=1: capture prdata (reads only) and pslverr → rsp_err, then go to RESP.
    - Otherwise increment the timeout counter. When the counter reaches TIMEOUT_CYCLES with pready still low, go to RESP with rsp_err=10 and rdata=0.
  - RESP: psel=penable=0; rsp_valid=1; rsp_* stable until rsp_ready.
    - On handshake with the FIFO non-empty: pop and go directly to SETUP.
    - On handshake with the FIFO empty: go to IDLE.
- All APB and rsp outputs are registered.
- Latency, zero-wait write:
  - Request accepted in cycle N.
  - psel rises at N+2; penable at N+3.
  - With pready=1 at N+3, rsp_valid=1 at N+4.
- Back-to-back throughput: one transfer per 3 cycles (psel low for exactly 1 cycle between transfers) when rsp_ready is held 1.
- pwdata and pstrb are forced to 0 for reads.
- pslverr is ignored when pready=0.
- The timeout counter clears on entry to SETUP.
- Requests can keep filling the FIFO while the FSM stalls in RESP.

Test Plan:
- Write addr=0x0000_0010, wdata=0xDEAD_BEEF, strb=0xF, pready tied 1: psel at N+2, penable at N+3, rsp_valid at N+4, rsp_err=00, pstrb=0xF during the transfer.
- Read addr=0x20, slave holds pready=0 for 3 ACCESS cycles then returns prdata=0x1234_5678: penable high for 4 cycles, paddr stable, rsp_rdata=0x1234_5678, rsp_err=00.
- Write with pready=1 and pslverr=1 in ACCESS: rsp_err=01, rsp_rdata=0; also check that pslverr=1 while pready=0 is ignored.
- Timeout, TIMEOUT_CYCLES=16, pready never asserted: ACCESS lasts exactly 16 cycles, then psel/penable drop and rsp_err=10.
- Backpressure: hold rsp_ready=0 and push 6 requests: req_ready drops after 4 FIFO entries plus 1 loaded command. Releasing rsp_ready drains all 5 in order with one idle psel cycle between transfers.
- Assert rst for 1 cycle during ACCESS of a read with 2 requests queued: next cycle all APB outputs are 0, rsp_valid=0, req_ready=1, and no stale response ever appears.
